// File: rtl/uart_test_check.sv
// uart_test_check: checks that bytes from uartrx form an incrementing
// 8-bit sequence. It acquires lock, counts good and bad bytes, and drops
// lock when the link goes silent.
module uart_test_check #(
    parameter int unsigned LOCK_COUNT     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       datain,
    input  logic             rdsig,
    input  logic             frame_err,
    input  logic             clr,
    output logic             locked,
    output logic             err,
    output logic             timeout,
    output logic [7:0]       expected,
    output logic [CNT_W-1:0] ok_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int unsigned IDLE_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t              state, state_n;
    logic [3:0]          match_cnt, match_cnt_n;
    logic [IDLE_W-1:0]   idle_cnt, idle_cnt_n;
    logic [7:0]          expected_n;
    logic                err_n, timeout_n;
    logic                ok_inc, err_inc;
    logic                is_match, expiry;
    logic [3:0]          match_inc;

    assign is_match  = rdsig && !frame_err && (datain == expected);
    assign expiry    = !rdsig && (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));
    assign match_inc = match_cnt + 4'd1;

    // Next-state, sequence tracking and event decode.
    always_comb begin
        state_n     = state;
        match_cnt_n = match_cnt;
        idle_cnt_n  = idle_cnt;
        expected_n  = expected;
        err_n       = 1'b0;
        timeout_n   = 1'b0;
        ok_inc      = 1'b0;
        err_inc     = 1'b0;
        case (state)
            ST_IDLE: begin
                idle_cnt_n = '0;
                if (rdsig && !frame_err) begin
                    expected_n  = datain + 8'd1;
                    match_cnt_n = 4'd1;
                    state_n     = (LOCK_COUNT == 1) ? ST_LOCKED : ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (rdsig) begin
                    idle_cnt_n = '0;
                    if (frame_err) begin
                        state_n     = ST_IDLE;
                        match_cnt_n = '0;
                    end else if (is_match) begin
                        match_cnt_n = match_inc;
                        expected_n  = datain + 8'd1;
                        if (match_inc == 4'(LOCK_COUNT))
                            state_n = ST_LOCKED;
                    end else begin
                        match_cnt_n = 4'd1;
                        expected_n  = datain + 8'd1;
                    end
                end else if (expiry) begin
                    state_n     = ST_IDLE;
                    match_cnt_n = '0;
                    idle_cnt_n  = '0;
                end else begin
                    idle_cnt_n = idle_cnt + 1'b1;
                end
            end
            ST_LOCKED: begin
                if (rdsig) begin
                    idle_cnt_n = '0;
                    if (frame_err) begin
                        // A lost byte still occupies one sequence slot.
                        err_n      = 1'b1;
                        err_inc    = 1'b1;
                        expected_n = expected + 8'd1;
                    end else if (is_match) begin
                        ok_inc     = 1'b1;
                        expected_n = datain + 8'd1;
                    end else begin
                        err_n      = 1'b1;
                        err_inc    = 1'b1;
                        expected_n = datain + 8'd1;
                    end
                end else if (expiry) begin
                    state_n     = ST_IDLE;
                    match_cnt_n = '0;
                    idle_cnt_n  = '0;
                    timeout_n   = 1'b1;
                end else begin
                    idle_cnt_n = idle_cnt + 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            match_cnt <= '0;
            idle_cnt  <= '0;
            expected  <= '0;
            locked    <= 1'b0;
            err       <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_n;
            match_cnt <= match_cnt_n;
            idle_cnt  <= idle_cnt_n;
            expected  <= expected_n;
            locked    <= (state_n == ST_LOCKED);
            err       <= err_n;
            timeout   <= timeout_n;
        end
    end

    // Good/bad byte counters; clr overrides a coincident count.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            ok_cnt  <= '0;
            err_cnt <= '0;
        end else begin
            if (ok_inc)
                ok_cnt <= ok_cnt + 1'b1;
            if (err_inc && (err_cnt != '1))
                err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_test_check.sv
// Self-checking bench for uart_test_check: directed table, hand-written
// boundary sequences and randomized traffic against a behavioural model.
module tb_uart_test_check;

    localparam int LOCK = 4;
    localparam int TO   = 4096;
    localparam int CW   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    datain;
    logic          rdsig;
    logic          frame_err;
    logic          clr;
    logic          locked;
    logic          err;
    logic          timeout;
    logic [7:0]    expected;
    logic [CW-1:0] ok_cnt;
    logic [CW-1:0] err_cnt;

    int checks   = 0;
    int failures = 0;

    uart_test_check #(
        .LOCK_COUNT    (LOCK),
        .TIMEOUT_CYCLES(TO),
        .CNT_W         (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .datain   (datain),
        .rdsig    (rdsig),
        .frame_err(frame_err),
        .clr      (clr),
        .locked   (locked),
        .err      (err),
        .timeout  (timeout),
        .expected (expected),
        .ok_cnt   (ok_cnt),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural model: run length of in-sequence bytes, lock flag,
    // cycles of silence, and plain integer counters.
    bit       m_locked;
    int       m_run;
    int       m_silent;
    bit [7:0] m_exp;
    int       m_ok;
    int       m_errc;
    bit       m_err;
    bit       m_to;

    always @(posedge clk) begin
        bit ok_ev, err_ev;
        ok_ev  = 0;
        err_ev = 0;
        m_err  = 0;
        m_to   = 0;
        if (rst) begin
            m_locked = 0; m_run = 0; m_silent = 0; m_exp = 0; m_ok = 0; m_errc = 0;
        end else begin
            if (m_locked) begin
                if (rdsig) begin
                    m_silent = 0;
                    if (frame_err) begin
                        err_ev = 1;
                        m_exp  = m_exp + 8'd1;
                    end else begin
                        if (datain == m_exp) ok_ev = 1; else err_ev = 1;
                        m_exp = datain + 8'd1;
                    end
                end else if (m_silent == TO - 1) begin
                    m_to = 1; m_locked = 0; m_run = 0; m_silent = 0;
                end else begin
                    m_silent++;
                end
            end else if (m_run == 0) begin
                m_silent = 0;
                if (rdsig && !frame_err) begin
                    m_exp = datain + 8'd1;
                    m_run = 1;
                    if (LOCK == 1) m_locked = 1;
                end
            end else begin
                if (rdsig) begin
                    m_silent = 0;
                    if (frame_err) begin
                        m_run = 0;
                    end else begin
                        m_run = (datain == m_exp) ? m_run + 1 : 1;
                        m_exp = datain + 8'd1;
                        if (m_run == LOCK) m_locked = 1;
                    end
                end else if (m_silent == TO - 1) begin
                    m_run = 0; m_silent = 0;
                end else begin
                    m_silent++;
                end
            end
            m_err = err_ev;
            if (clr) begin
                m_ok = 0; m_errc = 0;
            end else begin
                m_ok   = (m_ok + int'(ok_ev)) % (1 << CW);
                m_errc = (m_errc + int'(err_ev) > (1 << CW) - 1) ? (1 << CW) - 1 : m_errc + int'(err_ev);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    // One clock: advance past the edge, then compare DUT against the model.
    task automatic tick();
        @(posedge clk);
        #1;
        check("model_locked", 32'(locked), 32'(m_locked));
        check("model_err", 32'(err), 32'(m_err));
        check("model_timeout", 32'(timeout), 32'(m_to));
        check("model_expected", 32'(expected), 32'(m_exp));
        check("model_ok_cnt", 32'(ok_cnt), 32'(m_ok));
        check("model_err_cnt", 32'(err_cnt), 32'(m_errc));
    endtask

    task automatic gap(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic strobe(input logic [7:0] d, input logic fe, input logic c);
        datain = d; frame_err = fe; clr = c; rdsig = 1'b1;
        tick();
        rdsig = 1'b0; frame_err = 1'b0; clr = 1'b0; datain = $urandom_range(0, 255);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [7:0]    d;
        logic          fe;
        logic          e_locked;
        logic          e_err;
        logic [7:0]    e_exp;
        logic [CW-1:0] e_ok;
        logic [CW-1:0] e_errc;
    } vec_t;

    vec_t tbl [16];

    initial begin
        logic [7:0] seq;
        int         g;

        tbl[0]  = '{8'h10, 1'b0, 1'b0, 1'b0, 8'h11, 4'd0, 4'd0};
        tbl[1]  = '{8'h11, 1'b0, 1'b0, 1'b0, 8'h12, 4'd0, 4'd0};
        tbl[2]  = '{8'h12, 1'b0, 1'b0, 1'b0, 8'h13, 4'd0, 4'd0};
        tbl[3]  = '{8'h13, 1'b0, 1'b1, 1'b0, 8'h14, 4'd0, 4'd0};
        tbl[4]  = '{8'h14, 1'b0, 1'b1, 1'b0, 8'h15, 4'd1, 4'd0};
        tbl[5]  = '{8'hFD, 1'b0, 1'b1, 1'b1, 8'hFE, 4'd1, 4'd1};
        tbl[6]  = '{8'hFE, 1'b0, 1'b1, 1'b0, 8'hFF, 4'd2, 4'd1};
        tbl[7]  = '{8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, 4'd3, 4'd1};
        tbl[8]  = '{8'h00, 1'b0, 1'b1, 1'b0, 8'h01, 4'd4, 4'd1};
        tbl[9]  = '{8'h01, 1'b0, 1'b1, 1'b0, 8'h02, 4'd5, 4'd1};
        tbl[10] = '{8'h1F, 1'b0, 1'b1, 1'b1, 8'h20, 4'd5, 4'd2};
        tbl[11] = '{8'h25, 1'b0, 1'b1, 1'b1, 8'h26, 4'd5, 4'd3};
        tbl[12] = '{8'h26, 1'b0, 1'b1, 1'b0, 8'h27, 4'd6, 4'd3};
        tbl[13] = '{8'h2F, 1'b0, 1'b1, 1'b1, 8'h30, 4'd6, 4'd4};
        tbl[14] = '{8'hAA, 1'b1, 1'b1, 1'b1, 8'h31, 4'd6, 4'd5};
        tbl[15] = '{8'h31, 1'b0, 1'b1, 1'b0, 8'h32, 4'd7, 4'd5};

        rst = 1'b1; rdsig = 1'b0; frame_err = 1'b0; clr = 1'b0; datain = 8'h00;
        tick();
        tick();
        check("reset_locked", 32'(locked), 32'd0);
        check("reset_expected", 32'(expected), 32'd0);
        check("reset_ok_cnt", 32'(ok_cnt), 32'd0);
        check("reset_err_cnt", 32'(err_cnt), 32'd0);
        rst = 1'b0;

        // Directed table: acquire, wrap, mismatch, frame error.
        for (int i = 0; i < 16; i++) begin
            gap(1017);
            strobe(tbl[i].d, tbl[i].fe, 1'b0);
            check($sformatf("tbl%0d_locked", i), 32'(locked), 32'(tbl[i].e_locked));
            check($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].e_err));
            check($sformatf("tbl%0d_expected", i), 32'(expected), 32'(tbl[i].e_exp));
            check($sformatf("tbl%0d_ok_cnt", i), 32'(ok_cnt), 32'(tbl[i].e_ok));
            check($sformatf("tbl%0d_err_cnt", i), 32'(err_cnt), 32'(tbl[i].e_errc));
            tick();
            check($sformatf("tbl%0d_err_one_cycle", i), 32'(err), 32'd0);
        end

        // Timeout at exactly TO silent cycles after the last strobe.
        strobe(8'h32, 1'b0, 1'b0);
        gap(TO - 1);
        check("to_before_pulse", 32'(timeout), 32'd0);
        check("to_before_locked", 32'(locked), 32'd1);
        tick();
        check("to_pulse", 32'(timeout), 32'd1);
        check("to_unlocked", 32'(locked), 32'd0);
        tick();
        check("to_pulse_one_cycle", 32'(timeout), 32'd0);

        // rdsig on the expiry cycle keeps lock.
        for (int i = 0; i < 4; i++) strobe(8'h40 + 8'(i), 1'b0, 1'b0);
        check("relock", 32'(locked), 32'd1);
        gap(TO - 1);
        strobe(8'h44, 1'b0, 1'b0);
        check("expiry_rd_no_timeout", 32'(timeout), 32'd0);
        check("expiry_rd_locked", 32'(locked), 32'd1);
        check("expiry_rd_expected", 32'(expected), 32'h45);
        tick();
        check("expiry_rd_no_late_timeout", 32'(timeout), 32'd0);

        // err_cnt saturation, then clr colliding with an error.
        for (int i = 0; i < 17; i++) strobe(8'h77, 1'b0, 1'b0);
        check("sat_err_cnt", 32'(err_cnt), 32'd15);
        strobe(8'h77, 1'b0, 1'b1);
        check("clr_err_pulse", 32'(err), 32'd1);
        check("clr_err_cnt", 32'(err_cnt), 32'd0);
        check("clr_ok_cnt", 32'(ok_cnt), 32'd0);
        check("clr_keeps_lock", 32'(locked), 32'd1);

        // Reset in the middle of SYNC, coincident with a strobe.
        strobe(8'h90, 1'b0, 1'b0);
        do_reset();
        strobe(8'h05, 1'b0, 1'b0);
        strobe(8'h06, 1'b0, 1'b0);
        rst = 1'b1;
        strobe(8'h07, 1'b0, 1'b0);
        rst = 1'b0;
        check("rst_sync_locked", 32'(locked), 32'd0);
        check("rst_sync_expected", 32'(expected), 32'd0);
        check("rst_sync_err", 32'(err), 32'd0);
        // Sequence restarts from scratch: three more bytes are not enough.
        strobe(8'h08, 1'b0, 1'b0);
        strobe(8'h09, 1'b0, 1'b0);
        strobe(8'h0A, 1'b0, 1'b0);
        check("rst_sync_no_early_lock", 32'(locked), 32'd0);

        // Frame error in SYNC returns to IDLE and restarts acquisition.
        do_reset();
        strobe(8'h50, 1'b0, 1'b0);
        strobe(8'h51, 1'b0, 1'b0);
        strobe(8'h00, 1'b1, 1'b0);
        check("sync_fe_no_err", 32'(err), 32'd0);
        check("sync_fe_expected_held", 32'(expected), 32'h52);
        strobe(8'h52, 1'b0, 1'b0);
        strobe(8'h53, 1'b0, 1'b0);
        check("sync_fe_restart", 32'(locked), 32'd0);
        strobe(8'h54, 1'b0, 1'b0);
        strobe(8'h55, 1'b0, 1'b0);
        check("sync_fe_relock", 32'(locked), 32'd1);

        // Randomized traffic checked every cycle by the model.
        do_reset();
        seq = 8'($urandom_range(0, 255));
        for (int i = 0; i < 2500; i++) begin
            int         r;
            logic [7:0] d;
            logic       fe, c;
            if (i % 500 == 250)
                g = (i % 1000 == 250) ? TO - 1 : TO;
            else
                g = $urandom_range(0, 4);
            gap(g);
            r  = $urandom_range(0, 99);
            fe = (r >= 85 && r < 90);
            d  = (r >= 77 && r < 85) ? 8'($urandom_range(0, 255)) : seq;
            c  = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 199) == 0) rst = 1'b1;
            strobe(d, fe, c);
            rst = 1'b0;
            seq = fe ? seq + 8'd1 : d + 8'd1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
